// File: rtl/spi_target_regfile.sv
// spi_target_regfile: SPI mode-0 target exposing 32 x 8-bit registers.
// A transaction is one command byte {addr[4:0], x, dir, x} (dir=1 is a write)
// followed by any number of data bytes. The same registers are also reachable
// through a local read/write port. Every completed SPI write byte is reported
// on wr_strobe/wr_addr/wr_data.
// Optional build macro: SPI_AUTOINC_EN - the address advances (wrapping
// 31 -> 0) after every data byte; without it the address stays fixed for the
// whole transaction.
module spi_target_regfile #(
    parameter logic [7:0] STATUS_BYTE = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_ss_n,
    output logic       spi_miso,
    input  logic [4:0] loc_addr,
    output logic [7:0] loc_rdata,
    input  logic       loc_we,
    input  logic [7:0] loc_wdata,
    output logic       wr_strobe,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ss_n_sync;
    logic              r_sclk_prev;
    logic              r_ss_n_prev;

    logic [2:0]        r_bit_cnt;
    logic [6:0]        r_rx;
    logic [8:0]        r_tx;
    logic [4:0]        r_addr;
    logic              r_dir_wr;
    logic              r_wr_strobe;
    logic [4:0]        r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [7:0]        r_regs [32];

    logic              w_sclk;
    logic              w_mosi;
    logic              w_ss_n;
    logic              w_rise;
    logic              w_fall;
    logic              w_ss_fall;
    logic              w_byte_done;
    logic [7:0]        w_byte;
    logic              w_spi_we;
    logic [4:0]        w_addr_next;

    // Bring the SPI pins into the clk_clk domain and keep one extra sample for edge detection.
    // SS_n resets to "selected" so a transfer already running when reset lifts
    // never produces a falling edge; it is ignored until SS_n toggles high then low.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_n_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_ss_n_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the previous
            // value of its neighbour, which is what makes this a shift chain.
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_ss_n_sync <= {r_ss_n_sync[SYNC_STAGES-2:0], spi_ss_n};
            r_sclk_prev <= w_sclk;
            r_ss_n_prev <= w_ss_n;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss_n      = r_ss_n_sync[SYNC_STAGES-1];
    assign w_rise      = w_sclk & ~r_sclk_prev;
    assign w_fall      = ~w_sclk & r_sclk_prev;
    assign w_ss_fall   = r_ss_n_prev & ~w_ss_n;
    assign w_byte      = {r_rx, w_mosi};
    assign w_byte_done = w_rise & (r_bit_cnt == 3'd7) & ~w_ss_n;
    assign w_spi_we    = (r_state == ST_DATA) & w_byte_done & r_dir_wr;

`ifdef SPI_AUTOINC_EN
    assign w_addr_next = r_addr + 5'd1;
`else
    assign w_addr_next = r_addr;
`endif

    // Transaction state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: deselect aborts from any state.
    always_comb begin
        // NOTE: default first so every path assigns w_state_next and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_ss_fall) w_state_next = ST_CMD;
            ST_CMD: begin
                if (w_ss_n)           w_state_next = ST_IDLE;
                else if (w_byte_done) w_state_next = ST_DATA;
            end
            ST_DATA: if (w_ss_n) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Shift datapath: sample on SCLK rise, shift MISO on SCLK fall, decode at byte boundaries.
    // r_tx[8] drives MISO; byte reloads go into r_tx[7:0] so the bit currently on
    // the line holds until the following fall shifts the new MSB into place.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_bit_cnt   <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_addr      <= '0;
            r_dir_wr    <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_ss_n || r_state == ST_IDLE) begin
                r_bit_cnt <= '0;
                r_rx      <= '0;
                r_tx      <= (r_state == ST_IDLE && w_ss_fall) ? {STATUS_BYTE, 1'b0} : 9'd0;
            end else begin
                if (w_rise) begin
                    r_rx      <= w_byte[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                if (w_fall) begin
                    r_tx <= {r_tx[7:0], 1'b0};
                end
                if (w_byte_done) begin
                    if (r_state == ST_CMD) begin
                        r_addr   <= w_byte[7:3];
                        r_dir_wr <= w_byte[1];
                        r_tx     <= {r_tx[8], w_byte[1] ? 8'h00 : r_regs[w_byte[7:3]]};
                    end else if (r_dir_wr) begin
                        r_wr_strobe <= 1'b1;
                        r_wr_addr   <= r_addr;
                        r_wr_data   <= w_byte;
                        r_addr      <= w_addr_next;
                    end else begin
                        r_tx   <= {r_tx[8], r_regs[w_addr_next]};
                        r_addr <= w_addr_next;
                    end
                end
            end
        end
    end

    // Register file: local write first, SPI write last so it wins on an address clash.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            // NOTE: this array is reset on purpose (registers read 0 after reset),
            // which keeps it in flops instead of block RAM.
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            if (loc_we) begin
                r_regs[loc_addr] <= loc_wdata;
            end
            if (w_spi_we) begin
                r_regs[r_addr] <= w_byte;
            end
        end
    end

    assign spi_miso  = r_tx[8];
    assign loc_rdata = r_regs[loc_addr];
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_target_regfile.sv
// tb_spi_target_regfile: directed SPI master plus scoreboard for spi_target_regfile.
// Stimulus pushes expected MISO bytes and expected write strobes into queues;
// two monitors pop and compare whenever the DUT presents a byte or a strobe.
module tb_spi_target_regfile;

    localparam logic [7:0] TB_STATUS = 8'hA6;
    localparam int         HALF      = 4;   // SCLK half period in clk_clk cycles (SCLK = clk/8)

    logic       clk_clk       = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic       spi_sclk      = 1'b0;
    logic       spi_mosi      = 1'b0;
    logic       spi_ss_n      = 1'b1;
    logic [4:0] loc_addr      = '0;
    logic       loc_we        = 1'b0;
    logic [7:0] loc_wdata     = '0;
    logic       spi_miso;
    logic [7:0] loc_rdata;
    logic       wr_strobe;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    typedef struct packed {
        logic       care;
        logic [7:0] val;
    } miso_exp_t;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_exp_t;

    miso_exp_t exp_miso [$];
    wr_exp_t   exp_wr   [$];
    int        total = 0;
    int        bad   = 0;

    spi_target_regfile #(
        .STATUS_BYTE (TB_STATUS),
        .SYNC_STAGES (2)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .spi_sclk      (spi_sclk),
        .spi_mosi      (spi_mosi),
        .spi_ss_n      (spi_ss_n),
        .spi_miso      (spi_miso),
        .loc_addr      (loc_addr),
        .loc_rdata     (loc_rdata),
        .loc_we        (loc_we),
        .loc_wdata     (loc_wdata),
        .wr_strobe     (wr_strobe),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_miso(input logic care, input logic [7:0] val);
        exp_miso.push_back('{care: care, val: val});
    endtask

    task automatic push_wr(input logic [4:0] addr, input logic [7:0] data);
        exp_wr.push_back('{addr: addr, data: data});
    endtask

    // Mode-0 master: MOSI set while SCLK low, SCLK rises mid-bit, MSB first.
    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            repeat (HALF) @(negedge clk_clk);
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge clk_clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_ss_low();
        @(negedge clk_clk);
        spi_ss_n = 1'b0;
        repeat (HALF) @(negedge clk_clk);
    endtask

    task automatic spi_ss_high();
        repeat (HALF) @(negedge clk_clk);
        spi_ss_n = 1'b1;
        repeat (8) @(negedge clk_clk);
    endtask

    task automatic loc_check(input string name, input logic [4:0] addr, input logic [7:0] exp);
        loc_addr = addr;
        #1;
        check(name, loc_rdata, exp);
    endtask

    // Keep a local write asserted until the DUT's SPI commit is visible, so the
    // local write overlaps the SPI commit cycle exactly once at its end.
    task automatic hold_loc_until_strobe();
        int waited;
        waited = 0;
        do begin
            @(negedge clk_clk);
            waited++;
        end while (wr_strobe !== 1'b1 && waited < 400);
        loc_we = 1'b0;
        check("collision_strobe_seen", wr_strobe, 1);
    endtask

    // MISO monitor: sample on each SCLK rise while selected, compare every full byte.
    logic      mon_armed = 1'b0;
    int        mon_cnt   = 0;
    logic [7:0] mon_shift = '0;
    miso_exp_t mon_e;
    always @(posedge spi_sclk or negedge spi_ss_n or posedge spi_ss_n or negedge reset_reset_n) begin
        if (!reset_reset_n || spi_ss_n) begin
            mon_armed = 1'b0;
            mon_cnt   = 0;
        end else if (!spi_sclk) begin
            mon_armed = 1'b1;
            mon_cnt   = 0;
        end else if (mon_armed) begin
            mon_shift = {mon_shift[6:0], spi_miso};
            mon_cnt++;
            if (mon_cnt == 8) begin
                mon_cnt = 0;
                check("miso_queued", exp_miso.size() != 0, 1);
                if (exp_miso.size() != 0) begin
                    mon_e = exp_miso.pop_front();
                    if (mon_e.care) check("miso_byte", mon_shift, mon_e.val);
                end
            end
        end
    end

    // Strobe monitor: each high cycle of wr_strobe must match one queued write.
    wr_exp_t wr_e;
    always @(negedge clk_clk) begin
        if (reset_reset_n && wr_strobe === 1'b1) begin
            check("strobe_queued", exp_wr.size() != 0, 1);
            if (exp_wr.size() != 0) begin
                wr_e = exp_wr.pop_front();
                check("wr_addr", wr_addr, wr_e.addr);
                check("wr_data", wr_data, wr_e.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk_clk);
        #1;
        check("rst_miso", spi_miso, 0);
        check("rst_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_loc_rdata", loc_rdata, 0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        repeat (4) @(negedge clk_clk);

        // Read addr 25 (cmd C8): status during command, 00 after reset
        push_miso(1'b1, TB_STATUS);
        push_miso(1'b1, 8'h00);
        spi_ss_low();
        check("busy_selected", busy, 1);
        spi_bits(8'hC8, 8);
        spi_bits(8'h00, 8);
        spi_ss_high();
        check("busy_deselected", busy, 0);
        check("miso_idle", spi_miso, 0);

        // Write addr 25 (cmd CA) with 1D, then read it back over SPI
        push_miso(1'b1, TB_STATUS);
        push_miso(1'b0, 8'h00);
        push_wr(5'd25, 8'h1D);
        spi_ss_low();
        spi_bits(8'hCA, 8);
        spi_bits(8'h1D, 8);
        spi_ss_high();
        loc_check("reg25_after_write", 5'd25, 8'h1D);
        push_miso(1'b1, TB_STATUS);
        push_miso(1'b1, 8'h1D);
        spi_ss_low();
        spi_bits(8'hC8, 8);
        spi_bits(8'h00, 8);
        spi_ss_high();

        // Two data bytes to addr 4 (cmd 22), then a two-byte read (cmd 20)
        push_miso(1'b1, TB_STATUS);
        push_miso(1'b0, 8'h00);
        push_miso(1'b0, 8'h00);
`ifdef SPI_AUTOINC_EN
        push_wr(5'd4, 8'hA5);
        push_wr(5'd5, 8'h3C);
`else
        push_wr(5'd4, 8'hA5);
        push_wr(5'd4, 8'h3C);
`endif
        spi_ss_low();
        spi_bits(8'h22, 8);
        spi_bits(8'hA5, 8);
        spi_bits(8'h3C, 8);
        spi_ss_high();
`ifdef SPI_AUTOINC_EN
        loc_check("reg4_burst", 5'd4, 8'hA5);
        loc_check("reg5_burst", 5'd5, 8'h3C);
        push_miso(1'b1, TB_STATUS);
        push_miso(1'b1, 8'hA5);
        push_miso(1'b1, 8'h3C);
`else
        loc_check("reg4_burst", 5'd4, 8'h3C);
        loc_check("reg5_burst", 5'd5, 8'h00);
        push_miso(1'b1, TB_STATUS);
        push_miso(1'b1, 8'h3C);
        push_miso(1'b1, 8'h3C);
`endif
        spi_ss_low();
        spi_bits(8'h20, 8);
        spi_bits(8'h00, 8);
        spi_bits(8'h00, 8);
        spi_ss_high();

        // Addr 7 = 11, then an aborted 5-bit data byte leaves it untouched
        push_miso(1'b1, TB_STATUS);
        push_miso(1'b0, 8'h00);
        push_wr(5'd7, 8'h11);
        spi_ss_low();
        spi_bits(8'h3A, 8);
        spi_bits(8'h11, 8);
        spi_ss_high();
        push_miso(1'b1, TB_STATUS);
        spi_ss_low();
        spi_bits(8'h3A, 8);
        spi_bits(8'hEE, 5);
        spi_ss_high();
        loc_check("reg7_after_abort", 5'd7, 8'h11);
        push_miso(1'b1, TB_STATUS);
        push_miso(1'b1, 8'h11);
        spi_ss_low();
        spi_bits(8'h38, 8);
        spi_bits(8'h00, 8);
        spi_ss_high();

        // Local write collides with SPI write to addr 9: SPI wins
        push_miso(1'b1, TB_STATUS);
        push_miso(1'b0, 8'h00);
        push_wr(5'd9, 8'hAA);
        loc_addr  = 5'd9;
        loc_wdata = 8'h55;
        loc_we    = 1'b1;
        fork
            begin
                spi_ss_low();
                spi_bits(8'h4A, 8);
                spi_bits(8'hAA, 8);
                spi_ss_high();
            end
            hold_loc_until_strobe();
        join
        loc_check("reg9_spi_wins", 5'd9, 8'hAA);

        // Same timing but local write to addr 10: both commit
        push_miso(1'b1, TB_STATUS);
        push_miso(1'b0, 8'h00);
        push_wr(5'd9, 8'hAA);
        loc_addr  = 5'd10;
        loc_wdata = 8'h55;
        loc_we    = 1'b1;
        fork
            begin
                spi_ss_low();
                spi_bits(8'h4A, 8);
                spi_bits(8'hAA, 8);
                spi_ss_high();
            end
            hold_loc_until_strobe();
        join
        loc_check("reg9_both", 5'd9, 8'hAA);
        loc_check("reg10_both", 5'd10, 8'h55);

        // Reset mid-byte of a write to addr 31
        push_miso(1'b1, TB_STATUS);
        loc_addr = 5'd9;
        spi_ss_low();
        spi_bits(8'hFA, 8);
        spi_bits(8'h77, 4);
        repeat (2) @(negedge clk_clk);
        spi_sclk = 1'b1;
        @(negedge clk_clk);
        reset_reset_n = 1'b0;
        #1;
        check("midrst_miso", spi_miso, 0);
        check("midrst_strobe", wr_strobe, 0);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_wr_data", wr_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_reg9", loc_rdata, 0);
        repeat (3) @(negedge clk_clk);
        spi_sclk = 1'b0;
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        repeat (4) @(negedge clk_clk);
        // Transfer still selected across reset release must be ignored
        spi_bits(8'hFA, 8);
        spi_bits(8'h5A, 8);
        spi_ss_high();
        loc_check("reg31_ignored", 5'd31, 8'h00);
        push_miso(1'b1, TB_STATUS);
        push_miso(1'b0, 8'h00);
        push_wr(5'd31, 8'hFF);
        spi_ss_low();
        spi_bits(8'hFA, 8);
        spi_bits(8'hFF, 8);
        spi_ss_high();
        loc_check("reg31_after_reset", 5'd31, 8'hFF);

        repeat (10) @(negedge clk_clk);
        check("wr_queue_drained", exp_wr.size(), 0);
        check("miso_queue_drained", exp_miso.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
